// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream_demux block.
package stream_demux_pkg;

  localparam int N_PORTS_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int ERR_CNT_W   = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_e;

endpackage

// File: rtl/stream_demux_if.sv
// Input beat + per-port output handshake bundle for stream_demux.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int DATA_W  = DATA_W_DEF
) ();

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [DATA_W-1:0]           in_data_i;
  logic [N_PORTS-1:0]          in_sel_i;
  logic [N_PORTS-1:0]          out_valid_o;
  logic [N_PORTS-1:0]          out_ready_i;
  logic [N_PORTS*DATA_W-1:0]   out_data_o;

  // Demux-side view.
  modport slave (
    input  in_valid_i, in_data_i, in_sel_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  // Environment view: upstream producer plus the per-lane consumers.
  modport master (
    output in_valid_i, in_data_i, in_sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry register slot for a single demux output lane.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);

  slot_st_e          st_p1;
  slot_st_e          st_nxt;
  logic [DATA_W-1:0] data_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_p1 <= SLOT_EMPTY;
    end else begin
      st_p1 <= st_nxt;
    end
  end

  // A load while draining keeps the slot full, so the lane runs without bubbles.
  always_comb begin
    st_nxt = st_p1;
    case (st_p1)
      SLOT_EMPTY: if (load_i) st_nxt = SLOT_FULL;
      SLOT_FULL:  if (!load_i && ready_i) st_nxt = SLOT_EMPTY;
      default:    st_nxt = SLOT_EMPTY;
    endcase
  end

  // ---- stage p1: payload register (holds last value once drained)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_p1 <= '0;
    end else if (load_i) begin
      data_p1 <= data_i;
    end
  end

  assign valid_o = (st_p1 == SLOT_FULL);
  assign full_o  = (st_p1 == SLOT_FULL);
  assign data_o  = data_p1;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready demultiplexer with one-hot select and per-port slots.
// Optional illegal-select counter: define STREAM_DEMUX_ERR_CNT_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  stream_demux_if.slave        bus,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic                             sel_legal;
  logic                             accept;
  logic                             drop;
  logic [N_PORTS-1:0]               load;
  logic [N_PORTS-1:0]               slot_vld;
  logic [N_PORTS-1:0]               slot_full;
  logic [N_PORTS-1:0][DATA_W-1:0]   slot_data;
  logic                             err_p1;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_legal = (bus.in_sel_i != '0) &&
                     ((bus.in_sel_i & (bus.in_sel_i - N_PORTS'(1))) == '0);

  // Illegal selects are always swallowed so a bad producer cannot wedge the input.
  assign bus.in_ready_o = sel_legal ? |(bus.in_sel_i & (~slot_full | bus.out_ready_i))
                                    : 1'b1;

  assign accept = bus.in_valid_i & bus.in_ready_o;
  assign drop   = accept & ~sel_legal;
  assign load   = {N_PORTS{accept & sel_legal}} & bus.in_sel_i;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[k]),
      .data_i  (bus.in_data_i),
      .valid_o (slot_vld[k]),
      .ready_i (bus.out_ready_i[k]),
      .data_o  (slot_data[k]),
      .full_o  (slot_full[k])
    );
  end

  assign bus.out_valid_o = slot_vld;
  assign bus.out_data_o  = slot_data;

  // ---- stage p1: error pulse registered one cycle after the dropped beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= drop;
    end
  end

  assign err_o = err_p1;

`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_p1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + ERR_CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_p1 <= '0;
    end else if (drop) begin
      err_cnt_p1 <= sat_inc(err_cnt_p1);
    end
  end

  assign err_cnt_o = err_cnt_p1;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Randomized bench for stream_demux against a per-port queue model.
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  stream_demux_if #(.N_PORTS(NP), .DATA_W(DW)) bus ();

  stream_demux #(.N_PORTS(NP), .DATA_W(DW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus.slave),
    .err_o     (err),
    .err_cnt_o (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each port is a queue of at most one beat.
  logic [DW-1:0] mq [NP][$];
  logic          err_exp = 1'b0;
  int            cnt_mdl = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic [NP-1:0] sel, input logic [NP-1:0] rdy);
    if ($countones(sel) != 1) return 1'b1;
    for (int k = 0; k < NP; k++)
      if (sel[k]) return (mq[k].size() == 0) || rdy[k];
    return 1'b1;
  endfunction

  function automatic int cnt_expected();
`ifdef STREAM_DEMUX_ERR_CNT_EN
    return (cnt_mdl > 255) ? 255 : cnt_mdl;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NP; k++) begin
      check_val($sformatf("vld%0d", k), bus.out_valid_o[k], mq[k].size() != 0);
      if (mq[k].size() != 0)
        check_val($sformatf("data%0d", k), bus.out_data_o[k*DW +: DW], mq[k][0]);
    end
    check_val("err", err, err_exp);
    check_val("err_cnt", err_cnt, cnt_expected());
  endtask

  // Drive one cycle of inputs (called with clk low), advance the model, check after the edge.
  task automatic step(input logic v, input logic [NP-1:0] sel, input logic [DW-1:0] d,
                      input logic [NP-1:0] rdy);
    logic exp_rdy;
    logic acc;
    logic legal;
    bus.in_valid_i  = v;
    bus.in_sel_i    = sel;
    bus.in_data_i   = d;
    bus.out_ready_i = rdy;
    #1;
    exp_rdy = model_ready(sel, rdy);
    check_val("in_ready", bus.in_ready_o, exp_rdy);
    legal = ($countones(sel) == 1);
    acc   = v && exp_rdy;
    for (int k = 0; k < NP; k++)
      if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
    if (acc && legal)
      for (int k = 0; k < NP; k++)
        if (sel[k]) mq[k].push_back(d);
    err_exp = acc && !legal;
    if (err_exp) cnt_mdl++;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [NP-1:0] rand_illegal();
    logic [NP-1:0] s;
    s = NP'($urandom_range(0, 15));
    while ($countones(s) == 1) s = NP'($urandom_range(0, 15));
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) mq[k].delete();
    err_exp = 1'b0;
    cnt_mdl = 0;
  endtask

  initial begin
    logic [NP-1:0] sel;
    rst_n           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_sel_i    = '0;
    bus.in_data_i   = '0;
    bus.out_ready_i = '0;
    #2;
    check_val("rst_vld", bus.out_valid_o, 4'b0000);
    check_val("rst_data", bus.out_data_o, 32'h0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_cnt", err_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic routing: one-cycle presence on port 2.
    step(1'b1, 4'b0100, 8'hA5, 4'b1111);
    check_val("route_vld", bus.out_valid_o, 4'b0100);
    check_val("route_data", bus.out_data_o[2*DW +: DW], 8'hA5);
    step(1'b0, 4'b0000, 8'h00, 4'b1111);
    check_val("route_gone", bus.out_valid_o, 4'b0000);

    // Backpressure on port 1, independent traffic to port 3.
    step(1'b1, 4'b0010, 8'h11, 4'b0000);
    step(1'b1, 4'b0010, 8'h22, 4'b0000);
    check_val("bp_hold", bus.out_data_o[1*DW +: DW], 8'h11);
    step(1'b1, 4'b1000, 8'h33, 4'b0000);
    check_val("bp_other", bus.out_valid_o, 4'b1010);
    step(1'b0, 4'b0000, 8'h00, 4'b1111);

    // Reload without bubble on port 0.
    step(1'b1, 4'b0001, 8'h01, 4'b1111);
    step(1'b1, 4'b0001, 8'h02, 4'b1111);
    check_val("reload_vld", bus.out_valid_o[0], 1'b1);
    check_val("reload_data", bus.out_data_o[0 +: DW], 8'h02);
    step(1'b0, 4'b0000, 8'h00, 4'b1111);

    // Illegal selects.
    step(1'b1, 4'b0000, 8'hEE, 4'b1111);
    check_val("ill0_err", err, 1'b1);
    step(1'b1, 4'b0110, 8'hEF, 4'b1111);
    check_val("ill1_err", err, 1'b1);
    check_val("ill_vld", bus.out_valid_o, 4'b0000);
    step(1'b0, 4'b0000, 8'h00, 4'b1111);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      sel = ($urandom_range(0, 7) == 0) ? NP'($urandom_range(0, 15))
                                        : NP'(1) << $urandom_range(0, NP-1);
      step($urandom_range(0, 3) != 0, sel, DW'($urandom), NP'($urandom));
    end

    // Counter saturation (counter stays 0 when the feature is off).
    for (int i = 0; i < 300; i++)
      step(1'b1, rand_illegal(), DW'($urandom), NP'($urandom));
    step(1'b0, 4'b0000, 8'h00, 4'b1111);

    // Asynchronous reset with port 2 holding a beat.
    step(1'b1, 4'b0100, 8'h5A, 4'b0000);
    check_val("pre_rst_vld", bus.out_valid_o[2], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_vld", bus.out_valid_o, 4'b0000);
    check_val("arst_data", bus.out_data_o, 32'h0);
    check_val("arst_cnt", err_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 8'h00, 4'b0000);
    step(1'b0, 4'b0100, 8'h00, 4'b1111);
    check_val("post_rst_vld", bus.out_valid_o, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
